// File: rtl/sensor_algo_cali_apply.sv
// Per-channel calibration: two banks of gain factors (shadow/active) behind an
// Avalon-MM slave, applied to a sample stream with round-half-up and
// saturation. Bank swap only happens on a start-of-frame sample.
module sensor_algo_cali_apply #(
    parameter int NUM_CH    = 160,
    parameter int CH_W      = 8,
    parameter int DATA_W    = 16,
    parameter int FAC_W     = 16,
    parameter int FRAC_BITS = 14,
    parameter int OUT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CH_W:0]            avs_address,
    input  logic                     avs_chipselect,
    input  logic                     avs_write,
    input  logic                     avs_read,
    input  logic [1:0]               avs_byteenable,
    input  logic [15:0]              avs_writedata,
    output logic [15:0]              avs_readdata,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     swap_req,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     out_err,
    output logic                     swap_pending,
    output logic                     active_bank,
    output logic                     init_busy
);
    localparam int PW = DATA_W + FAC_W + 1;
    localparam logic [15:0] UNITY    = 16'(1 << FRAC_BITS);
    localparam logic [15:0] FAC_MASK = 16'((64'd1 << FAC_W) - 64'd1);
    localparam logic signed [PW:0] RND     = (PW+1)'(1 << (FRAC_BITS - 1));
    localparam logic signed [PW:0] SAT_MAX = (PW+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [PW:0] SAT_MIN = (PW+1)'(-(64'sd1 <<< (OUT_W - 1)));
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state_reg, state_next;
    logic [CH_W-1:0] init_cnt_reg;
    logic init_wr;
    logic running;

    // Init sequencer: one unity write per cycle, then hand over to RUN
    always_comb begin
        state_next = state_reg;
        init_wr    = 1'b0;
        case (state_reg)
            ST_INIT: begin
                init_wr = 1'b1;
                if (init_cnt_reg == CH_W'(NUM_CH - 1)) state_next = ST_RUN;
            end
            default: state_next = state_reg;
        endcase
    end

    // State and init counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (init_wr) init_cnt_reg <= init_cnt_reg + 1'b1;
        end
    end

    assign init_busy = (state_reg == ST_INIT);
    assign running   = (state_reg == ST_RUN);

    // Host port decode; address bit CH_W picks shadow (0) or active (1)
    logic [CH_W-1:0] host_ch;
    logic host_ch_ok, host_sel_active, host_wr, host_rd_go, wr_bank;
    logic [15:0] wdata_m;
    assign host_ch         = avs_address[CH_W-1:0];
    assign host_sel_active = avs_address[CH_W];
    assign host_ch_ok      = ({1'b0, host_ch} < (CH_W+1)'(NUM_CH));
    assign host_wr         = running & avs_chipselect & avs_write & ~host_sel_active & host_ch_ok;
    assign host_rd_go      = avs_chipselect & avs_read;
    assign wr_bank         = ~active_bank;
    assign wdata_m         = avs_writedata & FAC_MASK;

    // Swap decision: a request arriving with the sop sample applies immediately
    logic pend_eff, samp_go, swap_now, eff_bank, in_ch_ok;
    assign pend_eff = swap_pending | swap_req;
    assign samp_go  = running & in_valid;
    assign swap_now = samp_go & in_sop & pend_eff;
    assign eff_bank = active_bank ^ swap_now;
    assign in_ch_ok = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));

    logic [CH_W-1:0] samp_idx, host_idx;
    assign samp_idx = in_ch_ok ? in_ch : '0;
    assign host_idx = host_ch_ok ? host_ch : '0;

    logic [15:0] fac_rd  [2];
    logic [15:0] host_rd [2];

    // One RAM per bank: single write port, registered sample and host reads
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [15:0] mem [NUM_CH];
        always_ff @(posedge clk) begin
            if (init_wr) begin
                mem[init_cnt_reg] <= UNITY;
            end else if (host_wr && (wr_bank == 1'(gi))) begin
                if (avs_byteenable[0]) mem[host_idx][7:0]  <= wdata_m[7:0];
                if (avs_byteenable[1]) mem[host_idx][15:8] <= wdata_m[15:8];
            end
            if (samp_go)    fac_rd[gi]  <= mem[samp_idx];
            if (host_rd_go) host_rd[gi] <= mem[host_idx];
        end
    end

    // Readback qualifiers only change on a read, so avs_readdata holds between reads
    logic rd_sel_reg, rd_zero_reg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_sel_reg  <= 1'b0;
            rd_zero_reg <= 1'b1;
        end else if (host_rd_go) begin
            rd_sel_reg  <= host_sel_active ? active_bank : ~active_bank;
            rd_zero_reg <= ~running | ~host_ch_ok;
        end
    end
    assign avs_readdata = rd_zero_reg ? 16'd0 : host_rd[rd_sel_reg];

    // Bank swap bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
        end else begin
            swap_pending <= pend_eff & ~swap_now;
            active_bank  <= eff_bank;
        end
    end

    logic v1_reg, sop1_reg, err1_reg, bank1_reg;
    logic [CH_W-1:0] ch1_reg, ch2_reg;
    logic signed [DATA_W-1:0] data1_reg;
    logic v2_reg, sop2_reg, err2_reg;
    logic signed [PW-1:0] prod2_reg;
    logic signed [PW-1:0] mul_a, mul_b;
    logic [FAC_W-1:0] fac1;

    assign fac1  = fac_rd[bank1_reg][FAC_W-1:0];
    assign mul_a = {{(PW-DATA_W){data1_reg[DATA_W-1]}}, data1_reg};
    assign mul_b = {{(PW-FAC_W){1'b0}}, fac1};

    // Stage 3 arithmetic: round half up, arithmetic shift, clamp
    logic signed [PW:0] rnd, shr;
    logic sat_hi, sat_lo;
    logic [OUT_W-1:0] res;
    always_comb begin
        rnd    = {prod2_reg[PW-1], prod2_reg} + RND;
        shr    = rnd >>> FRAC_BITS;
        sat_hi = (shr > SAT_MAX);
        sat_lo = (shr < SAT_MIN);
        res    = shr[OUT_W-1:0];
        if (sat_hi)      res = OUT_MAX;
        else if (sat_lo) res = OUT_MIN;
    end

    // Three-stage sample pipeline; sideband held while no valid sample passes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_reg <= 1'b0; sop1_reg <= 1'b0; err1_reg <= 1'b0; bank1_reg <= 1'b0;
            ch1_reg <= '0; data1_reg <= '0;
            v2_reg <= 1'b0; sop2_reg <= 1'b0; err2_reg <= 1'b0; ch2_reg <= '0;
            prod2_reg <= '0;
            out_valid <= 1'b0; out_sop <= 1'b0; out_ch <= '0;
            out_data <= '0; out_sat <= 1'b0; out_err <= 1'b0;
        end else begin
            v1_reg <= samp_go;
            if (samp_go) begin
                sop1_reg  <= in_sop;
                ch1_reg   <= in_ch;
                err1_reg  <= ~in_ch_ok;
                data1_reg <= in_data;
                bank1_reg <= eff_bank;
            end
            v2_reg <= v1_reg;
            if (v1_reg) begin
                sop2_reg  <= sop1_reg;
                ch2_reg   <= ch1_reg;
                err2_reg  <= err1_reg;
                prod2_reg <= err1_reg ? '0 : mul_a * mul_b;
            end
            out_valid <= v2_reg;
            if (v2_reg) begin
                out_sop  <= sop2_reg;
                out_ch   <= ch2_reg;
                out_err  <= err2_reg;
                out_sat  <= ~err2_reg & (sat_hi | sat_lo);
                out_data <= err2_reg ? '0 : res;
            end
        end
    end
endmodule

// File: doc/sensor_algo_cali_apply.md
Name: sensor_algo_cali_apply

Overview:
Parametrised successor to the per-channel calibration-factor RAM. It holds two banks of per-channel gain factors (shadow and active), writable and readable over an Avalon-MM slave. It applies the active-bank factor to a streamed sensor sample with fixed-point multiply, rounding and saturation. Bank swap is frame-synchronous, so a frame never mixes factor sets. It sits between the channel demultiplexer and the beam-position algorithm, and runs in a single clock domain.

Parameters:
NUM_CH, 160, number of sensor channels (factors per bank)
CH_W, 8, channel index width; 2**CH_W >= NUM_CH
DATA_W, 16, signed input sample width
FAC_W, 16, unsigned factor width (at most 16; host word is 16 bits)
FRAC_BITS, 14, fractional bits of factor; unity = 2**FRAC_BITS
OUT_W, 16, signed output sample width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
avs_address  in  CH_W+1  bit CH_W: 0=shadow bank, 1=active bank (read-only); low bits = channel
avs_chipselect  in  1  slave select
avs_write  in  1  write strobe
avs_read  in  1  read strobe
avs_byteenable  in  2  byte lanes for writes
avs_writedata  in  16  factor, right-aligned FAC_W bits
avs_readdata  out  16  factor, zero-extended; fixed read latency 1
in_valid  in  1  sample valid (no backpressure)
in_sop  in  1  first sample of frame
in_ch  in  CH_W  channel index
in_data  in  DATA_W  signed sample
swap_req  in  1  one-cycle pulse: request shadow/active swap
out_valid  out  1  calibrated sample valid
out_sop  out  1  delayed in_sop
out_ch  out  CH_W  delayed in_ch
out_data  out  OUT_W  calibrated signed sample
out_sat  out  1  saturation occurred on this sample
out_err  out  1  in_ch >= NUM_CH; out_data forced 0
swap_pending  out  1  swap requested, not yet applied
active_bank  out  1  index of current active bank
init_busy  out  1  unity-initialisation in progress

Behaviour:
- Reset values: all outputs 0, except init_busy=1. FSM enters INIT with init counter=0 and active_bank=0.
- INIT: each cycle, write unity into both banks at index init counter, then increment. After writing NUM_CH-1, go to RUN; init_busy deasserts on the next cycle. Duration is exactly NUM_CH cycles.
- INIT side effects: in_valid is ignored (out_valid stays 0), host writes are dropped, host reads return 0, swap_req is still latched into swap_pending.
- RUN host write: applies when chipselect&write, address[CH_W]=0 and channel < NUM_CH. Each byte lane is written per byteenable; bits above FAC_W are dropped. Writes to the active bank or to out-of-range channels are ignored.
- RUN host read: when chipselect&read, avs_readdata is valid on the next cycle. It returns the addressed bank's value, or 0 if channel >= NUM_CH. avs_readdata holds its value when no read is issued.
- Swap: swap_req sets swap_pending. On the first cycle with in_valid&in_sop&swap_pending, active_bank toggles and swap_pending clears. That sample and all later samples use the new active bank.
- Simultaneous swap_req and in_valid&in_sop with no prior pending: the swap is applied on that sample.
- A host write in the swap cycle targets the pre-swap shadow bank.
- No factor copy on swap; software must rewrite the new shadow bank.
- Reset mid-operation clears the pipeline and swap_pending, sets active_bank=0, and re-runs INIT.
- Pipeline, fixed latency 3, no bubbles:
  - S1: register sample and sideband; synchronous read of factor[active][in_ch].
  - S2: signed product = in_data * {0,factor}; width DATA_W+FAC_W+1.
  - S3: add 2**(FRAC_BITS-1), arithmetic shift right by FRAC_BITS, saturate to [-2**(OUT_W-1), 2**(OUT_W-1)-1]; set out_sat on clamp.
- out_err samples: out_data=0, out_sat=0.
- Sideband signals (out_sop, out_ch, out_err) are aligned with out_valid.
- out_data, out_ch and out_sop hold their values when out_valid=0.

Test Plan:
- Reset, wait 160 cycles: init_busy falls at cycle 160. Host read of shadow ch 5 returns 0x4000. Sample ch5=1000 gives out_data 1000 three cycles later.
- Host writes ch3=0x6000 (1.5) to shadow, swap_req, frame with ch3=-1000: out_data -1500 only from the first in_sop after the swap. Pre-swap sample ch3=-1000 gives -1000.
- Factor 0xFFFF, data 32767: out_data 32767, out_sat=1. Data -32768: out_data -32768, out_sat=1.
- Rounding: factor 0x2000 (0.5), data 3 gives 2; data -3 gives -1 (round half up).
- in_ch=200 gives out_err=1, out_data 0. Host write to address 200 or to active bank 0x103 leaves readback unchanged. byteenable=01 updates only the low byte.
- Assert reset mid-frame with swap_pending=1: out_valid 0, swap_pending 0, active_bank 0, INIT re-runs, and all factors read 0x4000.
